// File: rtl/nand_cmd_addr_seq_pkg.sv
// Shared state encoding and NAND opcode constants for the command/address sequencer.
package nand_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD1    = 3'd1,
    ADDR    = 3'd2,
    CMD2    = 3'd3,
    TWB     = 3'd4,
    WAIT_RB = 3'd5,
    DONE    = 3'd6
  } nand_state_e;

  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_PROG2  = 8'h10;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // States that put one byte on the bus using a WE low/high slot.
  function automatic logic is_slot_state(input nand_state_e s);
    return (s == CMD1) || (s == ADDR) || (s == CMD2);
  endfunction

endpackage

// File: rtl/nand_cmd_addr_seq_we_slot_timer.sv
// Per-slot WE phase counter: WE_LOW_CYC low cycles then WE_HIGH_CYC high cycles,
// with a slot_end pulse on the last cycle of each slot.
module nand_we_slot_timer #(
  parameter int WE_LOW_CYC  = 1,
  parameter int WE_HIGH_CYC = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic slot_end_o,
  output logic we_low_next_o
);

  localparam int SLOT_CYC = WE_LOW_CYC + WE_HIGH_CYC;
  localparam int CW       = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] LOW_CNT  = CW'(WE_LOW_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Phase counter; idles at zero so the next slot always starts with WE low.
  always_comb begin
    slot_end_o = run_i && (cnt_q == LAST_CNT);
    if (run_i && !slot_end_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    we_low_next_o = (cnt_d < LOW_CNT);
  end

  // Phase counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// NAND bus sequencer: cmd1, 1..ADDR_BYTES address cycles, optional cmd2 with R/B wait.
// Pins are registered from the next-state decode so they line up with the FSM state.
module nand_cmd_addr_seq
  import nand_pkg::*;
#(
  parameter int ADDR_BYTES  = 4,
  parameter int WE_LOW_CYC  = 1,
  parameter int WE_HIGH_CYC = 1,
  parameter int TWB_CYC     = 2,
  parameter int RB_TIMEOUT  = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [7:0]                         cmd1,
  input  logic [7:0]                         cmd2,
  input  logic                               use_cmd2,
  input  logic [8*ADDR_BYTES-1:0]            addr,
  input  logic [$clog2(ADDR_BYTES+1)-1:0]    n_addr,
  input  logic                               rb_n,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout,
  output logic                               CE,
  output logic                               CLE,
  output logic                               ALE,
  output logic                               WE,
  output logic [7:0]                         IOX
);

  localparam int NW       = $clog2(ADDR_BYTES + 1);
  localparam int WAIT_MAX = (TWB_CYC > RB_TIMEOUT) ? TWB_CYC : RB_TIMEOUT;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [NW-1:0] ADDR_MAX = NW'(ADDR_BYTES);
  localparam logic [WW-1:0] TWB_LAST = WW'(TWB_CYC - 1);
  localparam logic [WW-1:0] RB_LAST  = WW'(RB_TIMEOUT - 1);

  nand_state_e state_q, state_d;
  logic [NW-1:0] byte_q, byte_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [7:0]              cmd1_q, cmd2_q;
  logic                    use_cmd2_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [NW-1:0]           n_eff_q;
  logic [NW-1:0]           n_eff_s;

  logic rb_meta_q, rb_sync_q;

  logic       ce_q, ce_d;
  logic       cle_q, cle_d;
  logic       ale_q, ale_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic [7:0] iox_q, iox_d;

  logic       accept_s;
  logic       run_s;
  logic       slot_end_s;
  logic       we_low_next_s;
  logic [7:0] addr_byte_s;

  assign run_s = is_slot_state(state_q);

  nand_we_slot_timer #(
    .WE_LOW_CYC  (WE_LOW_CYC),
    .WE_HIGH_CYC (WE_HIGH_CYC)
  ) u_slot_timer (
    .clk_i         (clk),
    .rst_ni        (rst),
    .run_i         (run_s),
    .slot_end_o    (slot_end_s),
    .we_low_next_o (we_low_next_s)
  );

  // Out-of-range address counts fall back to the full address width.
  always_comb begin
    if ((n_addr == '0) || (n_addr > ADDR_MAX)) begin
      n_eff_s = ADDR_MAX;
    end else begin
      n_eff_s = n_addr;
    end
  end

  // Sequencing FSM, address byte index and shared TWB / R/B wait counter.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    accept_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_s  = 1'b1;
          state_d   = CMD1;
          byte_d    = '0;
          timeout_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD1: begin
        if (slot_end_s) begin
          state_d = ADDR;
        end else begin
          state_d = CMD1;
        end
      end
      ADDR: begin
        if (slot_end_s && (byte_q == n_eff_q - NW'(1))) begin
          state_d = use_cmd2_q ? CMD2 : DONE;
        end else if (slot_end_s) begin
          byte_d = byte_q + NW'(1);
        end else begin
          byte_d = byte_q;
        end
      end
      CMD2: begin
        if (slot_end_s) begin
          state_d = TWB;
          wait_d  = '0;
        end else begin
          state_d = CMD2;
        end
      end
      TWB: begin
        if (wait_q == TWB_LAST) begin
          state_d = WAIT_RB;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      WAIT_RB: begin
        // Ready wins over an expiry landing in the same cycle.
        if (rb_sync_q) begin
          state_d = DONE;
        end else if (wait_q == RB_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address byte that goes on the bus for the next-state byte index.
  always_comb begin
    addr_byte_s = 8'h00;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (byte_d == NW'(k)) begin
        addr_byte_s = addr_q[8*k +: 8];
      end else begin
        addr_byte_s = addr_byte_s;
      end
    end
  end

  // Pin values for the coming cycle, decoded from the next state.
  always_comb begin
    ce_d   = (state_d == IDLE) || (state_d == DONE);
    busy_d = !((state_d == IDLE) || (state_d == DONE));
    done_d = (state_d == DONE);
    cle_d  = (state_d == CMD1) || (state_d == CMD2);
    ale_d  = (state_d == ADDR);
    we_d   = !(is_slot_state(state_d) && we_low_next_s);
    case (state_d)
      CMD1:    iox_d = accept_s ? cmd1 : cmd1_q;
      ADDR:    iox_d = addr_byte_s;
      CMD2:    iox_d = cmd2_q;
      default: iox_d = iox_q;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
    end
  end

  // Request capture; inputs are only sampled on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd1_q     <= 8'h00;
      cmd2_q     <= 8'h00;
      use_cmd2_q <= 1'b0;
      addr_q     <= '0;
      n_eff_q    <= ADDR_MAX;
    end else if (accept_s) begin
      cmd1_q     <= cmd1;
      cmd2_q     <= cmd2;
      use_cmd2_q <= use_cmd2;
      addr_q     <= addr;
      n_eff_q    <= n_eff_s;
    end else begin
      cmd1_q     <= cmd1_q;
      cmd2_q     <= cmd2_q;
      use_cmd2_q <= use_cmd2_q;
      addr_q     <= addr_q;
      n_eff_q    <= n_eff_q;
    end
  end

  // Two-flop synchroniser for the asynchronous ready/busy line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= rb_n;
      rb_sync_q <= rb_meta_q;
    end
  end

  // Registered NAND pins and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q      <= 1'b1;
      cle_q     <= 1'b0;
      ale_q     <= 1'b0;
      we_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      iox_q     <= 8'h00;
    end else begin
      ce_q      <= ce_d;
      cle_q     <= cle_d;
      ale_q     <= ale_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      iox_q     <= iox_d;
    end
  end

  assign CE      = ce_q;
  assign CLE     = cle_q;
  assign ALE     = ale_q;
  assign WE      = we_q;
  assign IOX     = iox_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Randomised bench for nand_cmd_addr_seq: three parameterisations, a cycle-level expected
// pin trace built from slot/latency arithmetic, directed corner cases and a reset abort.
module tb_nand_cmd_addr_seq;
  import nand_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sel;
  logic [7:0]  cmd1, cmd2;
  logic        use_cmd2;
  logic [39:0] addr;
  logic [2:0]  n_addr;
  logic        rb_n;

  logic [2:0]      start_w;
  logic [2:0]      busy_w, done_w, to_w, ce_w, cle_w, ale_w, we_w;
  logic [2:0][7:0] iox_w;
  logic [14:0]     obs_s;

  int p_ab  [3] = '{4, 4, 5};
  int p_l   [3] = '{1, 3, 1};
  int p_h   [3] = '{1, 2, 1};
  int p_twb [3] = '{2, 3, 2};
  int p_rbt [3] = '{1024, 8, 64};

  logic [7:0] last_iox [3];
  logic       last_to  [3];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign start_w = start ? (3'b001 << sel) : 3'b000;

  nand_cmd_addr_seq u_dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .cmd1(cmd1), .cmd2(cmd2), .use_cmd2(use_cmd2),
    .addr(addr[31:0]), .n_addr(n_addr), .rb_n(rb_n), .busy(busy_w[0]), .done(done_w[0]),
    .timeout(to_w[0]), .CE(ce_w[0]), .CLE(cle_w[0]), .ALE(ale_w[0]), .WE(we_w[0]), .IOX(iox_w[0])
  );

  nand_cmd_addr_seq #(
    .ADDR_BYTES(4), .WE_LOW_CYC(3), .WE_HIGH_CYC(2), .TWB_CYC(3), .RB_TIMEOUT(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .cmd1(cmd1), .cmd2(cmd2), .use_cmd2(use_cmd2),
    .addr(addr[31:0]), .n_addr(n_addr), .rb_n(rb_n), .busy(busy_w[1]), .done(done_w[1]),
    .timeout(to_w[1]), .CE(ce_w[1]), .CLE(cle_w[1]), .ALE(ale_w[1]), .WE(we_w[1]), .IOX(iox_w[1])
  );

  nand_cmd_addr_seq #(
    .ADDR_BYTES(5), .WE_LOW_CYC(1), .WE_HIGH_CYC(1), .TWB_CYC(2), .RB_TIMEOUT(64)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start_w[2]), .cmd1(cmd1), .cmd2(cmd2), .use_cmd2(use_cmd2),
    .addr(addr), .n_addr(n_addr), .rb_n(rb_n), .busy(busy_w[2]), .done(done_w[2]),
    .timeout(to_w[2]), .CE(ce_w[2]), .CLE(cle_w[2]), .ALE(ale_w[2]), .WE(we_w[2]), .IOX(iox_w[2])
  );

  // Observed pins of the selected instance: {CE,busy,done,timeout,CLE,ALE,WE,IOX}.
  always_comb begin
    case (sel)
      2'd0:    obs_s = {ce_w[0], busy_w[0], done_w[0], to_w[0], cle_w[0], ale_w[0], we_w[0], iox_w[0]};
      2'd1:    obs_s = {ce_w[1], busy_w[1], done_w[1], to_w[1], cle_w[1], ale_w[1], we_w[1], iox_w[1]};
      2'd2:    obs_s = {ce_w[2], busy_w[2], done_w[2], to_w[2], cle_w[2], ale_w[2], we_w[2], iox_w[2]};
      default: obs_s = 15'h0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {CE,busy,done,to,CLE,ALE,WE,IOX}=%b_%h, expected %b_%h",
               tag, got[14:8], got[7:0], exp[14:8], exp[7:0]);
    end
  endtask

  // One request on instance d. rb_rise: cycles after the last slot cycle at which rb_n goes
  // high (-1 = never). spam: random start pulses and input churn while busy. abort_i: cycle
  // at which reset is asserted (-1 = none).
  task automatic run_seq(input int d, input logic [7:0] c1, input logic [7:0] c2, input logic u2,
                         input logic [39:0] a, input logic [2:0] n, input int rb_rise,
                         input bit spam, input int abort_i);
    int p, lo, ne, slots_end, e_wait, seen, done_i, s, ph;
    logic exp_to;
    logic [7:0] bytes[$];
    logic [7:0] last_b;
    logic [14:0] exp_v;
    lo = p_l[d];
    p  = lo + p_h[d];
    ne = ((n == 3'd0) || (int'(n) > p_ab[d])) ? p_ab[d] : int'(n);
    bytes.delete();
    bytes.push_back(c1);
    for (int k = 0; k < ne; k++) bytes.push_back(a[8*k +: 8]);
    if (u2) bytes.push_back(c2);
    last_b    = bytes[bytes.size()-1];
    slots_end = bytes.size() * p;
    exp_to    = 1'b0;
    if (!u2) begin
      done_i = slots_end + 1;
    end else begin
      e_wait = slots_end + p_twb[d] + 1;
      seen   = (rb_rise < 0) ? 32'h7fff_0000 : slots_end + rb_rise + 2;
      if (seen < e_wait) seen = e_wait;
      if (seen <= e_wait + p_rbt[d] - 1) begin
        done_i = seen + 1;
      end else begin
        done_i = e_wait + p_rbt[d];
        exp_to = 1'b1;
      end
    end

    @(negedge clk);
    sel = 2'(d);
    #1;
    check_eq($sformatf("idle_before d%0d", d), obs_s,
             {1'b1, 1'b0, 1'b0, last_to[d], 1'b0, 1'b0, 1'b1, last_iox[d]});
    cmd1 = c1; cmd2 = c2; use_cmd2 = u2; addr = a; n_addr = n;
    rb_n = ~u2;
    start = 1'b1;

    for (int i = 1; i <= done_i + 1; i++) begin
      @(negedge clk);
      if (i == abort_i) begin
        rst = 1'b0;
        #1;
        check_eq($sformatf("reset_same_cycle d%0d", d), obs_s, {7'b1000001, 8'h00});
        repeat (2) begin
          @(negedge clk);
          check_eq($sformatf("reset_hold d%0d", d), obs_s, {7'b1000001, 8'h00});
        end
        rst = 1'b1; start = 1'b0; rb_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          last_iox[k] = 8'h00;
          last_to[k]  = 1'b0;
        end
        return;
      end
      if (i <= slots_end) begin
        s  = (i - 1) / p;
        ph = (i - 1) % p;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, (s == 0) || (s == ne + 1), (s >= 1) && (s <= ne),
                 (ph >= lo), bytes[s]};
      end else if (i < done_i) begin
        exp_v = {4'b0100, 3'b001, last_b};
      end else if (i == done_i) begin
        exp_v = {1'b1, 1'b0, 1'b1, exp_to, 3'b001, last_b};
      end else begin
        exp_v = {1'b1, 1'b0, 1'b0, exp_to, 3'b001, last_b};
      end
      check_eq($sformatf("d%0d n%0d cmd2=%0d cyc%0d", d, ne, u2, i), obs_s, exp_v);
      start = 1'b0;
      if (spam && (i <= done_i)) start = ($urandom_range(0, 2) == 0) || (i == done_i);
      if (spam) begin
        cmd1 = 8'($urandom); cmd2 = 8'($urandom);
        addr = {8'($urandom), $urandom}; n_addr = 3'($urandom);
      end
      if (u2 && (rb_rise >= 0) && (i == slots_end + rb_rise)) rb_n = 1'b1;
    end
    start = 1'b0;
    rb_n  = 1'b1;
    last_iox[d] = last_b;
    last_to[d]  = exp_to;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sel = 2'd0; cmd1 = 8'h00; cmd2 = 8'h00; use_cmd2 = 1'b0;
    addr = 40'h0; n_addr = 3'd0; rb_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      last_iox[k] = 8'h00;
      last_to[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      check_eq($sformatf("reset_state d%0d", k), obs_s, {7'b1000001, 8'h00});
    end
    rst = 1'b1;

    run_seq(0, CMD_READ1, CMD_READ2, 1'b0, 40'h00_04030201, 3'd4, -1, 1'b0, -1);
    run_seq(1, CMD_PROG1, CMD_PROG2, 1'b0, 40'h00_a1b2c3d4, 3'd2, -1, 1'b0, -1);
    run_seq(2, CMD_READ1, CMD_READ2, 1'b1, 40'h05_04030201, 3'd5, 20, 1'b0, -1);
    run_seq(1, CMD_ERASE1, CMD_ERASE2, 1'b1, 40'h00_00123456, 3'd3, -1, 1'b0, -1);
    run_seq(1, CMD_READ1, CMD_READ2, 1'b1, 40'h00_0badcafe, 3'd4, 0, 1'b0, -1);
    run_seq(0, CMD_READ1, CMD_READ2, 1'b0, 40'h00_deadbeef, 3'd0, -1, 1'b1, -1);
    run_seq(2, CMD_RESET, CMD_READ2, 1'b0, 40'h9a_78563412, 3'd7, -1, 1'b1, -1);
    run_seq(0, CMD_PROG1, CMD_PROG2, 1'b0, 40'h00_11223344, 3'd4, -1, 1'b0, 8);
    run_seq(0, CMD_PROG1, CMD_PROG2, 1'b1, 40'h00_55667788, 3'd4, 5, 1'b0, -1);

    for (int r = 0; r < 30; r++) begin
      run_seq($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom),
              {8'($urandom), $urandom}, 3'($urandom),
              ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40)),
              1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
